// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one SEG_WIDTH-bit segment per stage, valid/ready at both ends.
// Define PRCA_OVF_EN to add the registered signed-overflow output Ovf.
module pipelined_rca #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef PRCA_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int N = WIDTH / SEG_WIDTH;

  logic advance;

  // Whole pipeline moves in lockstep; bubbles hold along with real beats.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int RW = WIDTH - k * SEG_WIDTH;

    logic [RW-1:0]              a_in;
    logic [RW-1:0]              b_in;
    logic                       c_in;
    logic                       v_in;
    logic [SEG_WIDTH:0]         seg_add;
    logic                       v_q;
    logic                       c_q;
    logic [(k+1)*SEG_WIDTH-1:0] s_q;

    assign seg_add = {1'b0, a_in[SEG_WIDTH-1:0]} + {1'b0, b_in[SEG_WIDTH-1:0]}
                   + {{SEG_WIDTH{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign a_in = A;
      assign b_in = Sub ? ~B : B;
      assign c_in = Sub | Cin;
      assign v_in = in_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q <= '0;
        end else if (advance) begin
          s_q <= seg_add[SEG_WIDTH-1:0];
        end
      end
    end else begin : g_src
      assign a_in = g_stage[k-1].g_skew.a_q;
      assign b_in = g_stage[k-1].g_skew.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;

      // Finished lower segments ride along so the whole word exits together.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q <= '0;
        end else if (advance) begin
          s_q <= {seg_add[SEG_WIDTH-1:0], g_stage[k-1].s_q};
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= seg_add[SEG_WIDTH];
      end
    end

    if (k < N - 1) begin : g_skew
      logic [RW-SEG_WIDTH-1:0] a_q;
      logic [RW-SEG_WIDTH-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[RW-1:SEG_WIDTH];
          b_q <= b_in[RW-1:SEG_WIDTH];
        end
      end
    end
  end

  assign out_valid = g_stage[N-1].v_q;
  assign Sum       = g_stage[N-1].s_q;
  assign Cout      = g_stage[N-1].c_q;

`ifdef PRCA_OVF_EN
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit of the last segment.
  assign msb_cin = g_stage[N-1].a_in[SEG_WIDTH-1] ^ g_stage[N-1].b_in[SEG_WIDTH-1]
                 ^ g_stage[N-1].seg_add[SEG_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Ovf <= 1'b0;
    end else if (advance) begin
      Ovf <= msb_cin ^ g_stage[N-1].seg_add[SEG_WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed and scoreboarded random checks for pipelined_rca (32/4 and 8/8 builds).
// Follows PRCA_OVF_EN to decide whether Ovf is connected and checked.
module tb_pipelined_rca;

`ifdef PRCA_OVF_EN
  localparam bit HAS_OVF = 1'b1;
`else
  localparam bit HAS_OVF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, sub = 1'b0, cout, ovf32;

  logic        w8_in_valid = 1'b0, w8_in_ready, w8_out_valid, w8_out_ready = 1'b1;
  logic [7:0]  w8_a = '0, w8_b = '0, w8_sum;
  logic        w8_cin = 1'b0, w8_sub = 1'b0, w8_cout, ovf8;

  pipelined_rca #(.WIDTH(32), .SEG_WIDTH(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Cout(cout)
`ifdef PRCA_OVF_EN
    , .Ovf(ovf32)
`endif
  );

  pipelined_rca #(.WIDTH(8), .SEG_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .A(w8_a), .B(w8_b), .Cin(w8_cin), .Sub(w8_sub),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .Sum(w8_sum), .Cout(w8_cout)
`ifdef PRCA_OVF_EN
    , .Ovf(ovf8)
`endif
  );

`ifndef PRCA_OVF_EN
  assign ovf32 = 1'b0;
  assign ovf8  = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum}, ovf forced to 0 when the option is not built
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [31:0] yy;
    logic [32:0] r;
    logic        v;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : c)};
    v  = (x[31] == yy[31]) && (r[31] != x[31]);
    return {HAS_OVF ? v : 1'b0, r[32], r[31:0]};
  endfunction

  task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic s,
                         input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (lat < 20) begin
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_result"}, {ovf32, cout, sum}, {HAS_OVF ? eo : 1'b0, ec, es});
    @(negedge clk);
    check({tag, "_single"}, 64'(out_valid), 64'd0);
  endtask

  logic [33:0] q[$];
  bit mon_en = 1'b0;
  bit acc = 1'b0;
  int sent = 0;
  int recv = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check("stream", {ovf32, cout, sum}, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            recv++;
          end
        end
      end
    end
  end

  logic [7:0] s8_a[3] = '{8'h01, 8'hF0, 8'h10};
  logic [7:0] s8_b[3] = '{8'h02, 8'h20, 8'h20};
  logic       s8_s[3] = '{1'b0, 1'b0, 1'b1};
  logic [8:0] s8_e[3] = '{9'h003, 9'h110, 9'h0F0};

  initial begin
    int cyc;
    int gen;
    int cnt;

    @(negedge clk); @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_w8_valid", 64'(w8_out_valid), 64'd0);
`ifdef PRCA_OVF_EN
    check("rst_ovf", 64'(ovf32), 64'd0);
`endif
    #2 rst = 1'b0;

    run_one("inc_wrap",   32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_one("sub_borrow", 32'h5,        32'h7,        1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_one("sub_pos",    32'h7,        32'h5,        1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    run_one("ovf_add",    32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_one("ovf_sub",    32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_one("mixed",      32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
    run_one("seg_carry",  32'h0000000F, 32'h0,        1'b1, 1'b0, 32'h00000010, 1'b0, 1'b0);
    run_one("sub_equal",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);

    // single-stage build: latency 1, then back-to-back streaming
    @(posedge clk); #1;
    w8_a = 8'h80; w8_b = 8'h80; w8_cin = 1'b0; w8_sub = 1'b0; w8_in_valid = 1'b1;
    @(posedge clk); #1;
    w8_in_valid = 1'b0;
    @(negedge clk);
    check("w8_lat1_valid", 64'(w8_out_valid), 64'd1);
    check("w8_lat1_result", {w8_cout, w8_sum}, 9'h100);
`ifdef PRCA_OVF_EN
    check("w8_lat1_ovf", 64'(ovf8), 64'd1);
`endif
    @(posedge clk); #1;
    w8_a = s8_a[0]; w8_b = s8_b[0]; w8_sub = s8_s[0]; w8_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin
        w8_a = s8_a[i+1]; w8_b = s8_b[i+1]; w8_sub = s8_s[i+1];
      end else begin
        w8_in_valid = 1'b0;
      end
      @(negedge clk);
      check("w8_stream_valid", 64'(w8_out_valid), 64'd1);
      check("w8_stream_result", {w8_cout, w8_sum}, s8_e[i]);
    end
    @(negedge clk);
    check("w8_stream_end", 64'(w8_out_valid), 64'd0);

    // random traffic against the scoreboard
    mon_en = 1'b1;
    cyc = 0;
    gen = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (!in_valid || acc) begin
        if (gen < 1000 && $urandom_range(0, 3) != 0) begin
          a = $urandom; b = $urandom;
          cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          gen++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (q.size() != 0 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    @(negedge clk);
    mon_en = 1'b0;
    check("rand_sent", 64'(sent), 64'd1000);
    check("rand_recv", 64'(recv), 64'd1000);
    check("rand_drained", 64'(q.size()), 64'd0);

    // fill and stall, then reset mid-cycle
    out_ready = 1'b0;
    cnt = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; cin = 1'b0; sub = 1'b0; b = 32'h100;
    while (cnt < 20) begin
      a = 32'(cnt + 1);
      cnt++;
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
    end
    check("stall_full", 64'(out_valid), 64'd1);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_head", {cout, sum}, 33'h000000101);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    run_one("post_rst", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_rst_quiet", 64'(cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor: the successor to our fixed-width 4-bit-segment ripple adders. A WIDTH-bit operation is split into SEG_WIDTH-bit segments, one per pipeline stage, with the inter-segment carry registered between stages. Operands enter and results leave through valid/ready handshakes. It sits in datapaths that need full-width add/sub at high clock rate and one result per cycle.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of SEG_WIDTH and at least SEG_WIDTH.
- SEG_WIDTH, 4: bits added per pipeline stage; number of stages N = WIDTH/SEG_WIDTH.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; ignored when Sub=1.
- Sub  input  1  0: A+B+Cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  carry out of MSB (for Sub=1: 1 = no borrow, A >= B unsigned).
- Ovf  output  1  signed overflow; present only with PRCA_OVF_EN.

## Operation
- Beat accepted when in_valid && in_ready; result beat delivered when out_valid && out_ready.
- Stage k (0..N-1) adds segment k of A and B' (B' = Sub ? ~B : B) with the carry from stage k-1; stage 0 carry-in = Sub ? 1 : Cin.
- Segments above k travel in skew registers; completed lower Sum segments travel in de-skew registers so that all segments of one beat emerge together at stage N-1.
- Each stage carries a valid bit; bubbles (in_valid=0) propagate as valid=0 entries.
- Stall rule: advance = !out_valid || out_ready. When advance=0 every stage holds, including bubbles. in_ready = advance (combinational from out_valid, out_ready).
- Beats are never dropped, duplicated or reordered.
- Sum, Cout, Ovf are stable while out_valid=1 && out_ready=0.
- Reset (any time, including mid-stream): all valid bits, carry registers, skew/de-skew registers, Sum, Cout, Ovf cleared to 0 asynchronously; in-flight beats are discarded. After rst deasserts, in_ready=1.

## Timing
- Latency: beat accepted at edge t appears with out_valid=1 after edge t+N-1 (visible in cycle following edge t+N-1 counted from acceptance edge as edge 1, i.e. N cycles accept-to-output) when not stalled.
- N=1 (SEG_WIDTH=WIDTH): single registered adder, latency 1.
- Throughput: one beat per cycle with out_ready held high.
- Each stall cycle adds exactly one cycle to the latency of every in-flight beat.
- Critical path: one SEG_WIDTH ripple chain plus stage mux; no path spans stages.
- Simultaneous accept and deliver in the same cycle is legal and required for full throughput.

## Configuration
- PRCA_OVF_EN defined: Ovf port exists; Ovf = carry into MSB XOR carry out of MSB, computed in stage N-1, registered and aligned with Sum; reset 0.
- PRCA_OVF_EN undefined: no Ovf port and no associated logic; all other behaviour identical.

## Test plan
- WIDTH=32, SEG_WIDTH=4, out_ready=1: A=0xFFFFFFFF, B=0, Cin=1, Sub=0 -> after 8 cycles Sum=0x00000000, Cout=1, Ovf=0.
- Sub=1, A=5, B=7, Cin=1 (ignored) -> Sum=0xFFFFFFFE, Cout=0, Ovf=0; A=7, B=5 -> Sum=2, Cout=1.
- PRCA_OVF_EN: A=0x7FFFFFFF, B=1, Sub=0, Cin=0 -> Sum=0x80000000, Cout=0, Ovf=1; A=0x80000000, B=1, Sub=1 -> Sum=0x7FFFFFFF, Ovf=1.
- 1000 random beats, random in_valid gaps, out_ready random 50% -> results match reference model in order, no loss/duplication, outputs stable during stall, in_ready low exactly when out_valid && !out_ready.
- Reset mid-stream with 5 beats in flight and out_ready=0 -> out_valid, Sum, Cout go 0 immediately; no pre-reset beat ever emerges; first beat after reset emerges 8 cycles after acceptance.
- WIDTH=8, SEG_WIDTH=8: A=0x80, B=0x80, Cin=0 -> Sum=0x00, Cout=1 after 1 cycle; back-to-back beats stream at 1 per cycle.
